// File: rtl/scan_seq_pkg.sv
// Shared types, sizes and the enabled-channel search for the channel scan sequencer.
package scan_seq_pkg;

    localparam int unsigned N_CH    = 16;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned LAST_CH = 15;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BLANK,
        SERVICE
    } scan_state_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] ch;
    } ch_pick_t;

    // Lowest enabled channel above cur (or at cur when incl is set).
    function automatic ch_pick_t pick_enabled(input logic [N_CH-1:0]  mask,
                                              input logic [SEL_W-1:0] cur,
                                              input logic             incl);
        ch_pick_t res;
        res = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
                res.found = 1'b1;
                res.ch    = SEL_W'(i);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/channel_scan_sequencer_if.sv
// Control, request handshake and demux-drive signals of the channel scan sequencer.
interface channel_scan_sequencer_if
    import scan_seq_pkg::*;
#(
    parameter int unsigned DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic               req_valid;
    logic [SEL_W-1:0]   req_ch;
    logic               req_ready;
    logic [SEL_W-1:0]   sel;
    logic               strobe;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mode, dwell, req_valid, req_ch,
        input  req_ready, sel, strobe, busy, done
    );

    modport slave (
        input  start, stop, mode, dwell, req_valid, req_ch,
        output req_ready, sel, strobe, busy, done
    );

endinterface

// File: rtl/dwell_counter.sv
// Down-counter timing the strobe-high phase of ACTIVE and SERVICE.
module dwell_counter #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DWELL_W-1:0] load_val,
    input  logic               dec,
    output logic               zero
);

    logic [DWELL_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec) begin
            cnt <= cnt - DWELL_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/channel_scan_sequencer.sv
// Sweeps the 16 demux channels with dwell/blank timing and serves single-channel requests.
// Optional per-channel skip mask enabled by defining SEQ_CH_MASK_EN.
module channel_scan_sequencer
    import scan_seq_pkg::*;
#(
    parameter int unsigned DWELL_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef SEQ_CH_MASK_EN
    input  logic [N_CH-1:0]          ch_en,
`endif
    channel_scan_sequencer_if.slave  bus
);

    scan_state_t      state, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] scan_ch, scan_ch_d;
    logic [SEL_W-1:0] resume_ch, resume_ch_d;
    logic             strobe_q, strobe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             mode_q, mode_d;
    logic             from_idle, from_idle_d;
    logic             after_svc, after_svc_d;
    logic             resume_end, resume_end_d;
    logic             req_ready_c, accept;
    logic             cnt_zero, cnt_load, cnt_dec;
    logic             start_ok, adv_end, tgt_end, tgt_idle;
    logic [SEL_W-1:0] first_ch, adv_ch, tgt_ch;

    // Channel stepping: first channel of a sweep and the successor of scan_ch.
`ifdef SEQ_CH_MASK_EN
    ch_pick_t first_pick, above_pick;

    always_comb begin
        first_pick = pick_enabled(ch_en, '0, 1'b1);
        above_pick = pick_enabled(ch_en, scan_ch, 1'b0);
        start_ok   = first_pick.found;
        first_ch   = first_pick.ch;
        adv_ch     = above_pick.found ? above_pick.ch : first_pick.ch;
        adv_end    = !above_pick.found && (mode_q || !first_pick.found);
    end
`else
    always_comb begin
        start_ok = 1'b1;
        first_ch = '0;
        adv_ch   = SEL_W'(scan_ch + 1'b1);
        adv_end  = mode_q && (scan_ch == SEL_W'(LAST_CH));
    end
`endif

    assign req_ready_c = (state == IDLE) || (state == BLANK);
    assign accept      = bus.req_valid && req_ready_c;

    // Where a BLANK goes when no request is taken: back to idle, resume point, or next channel.
    assign tgt_idle = after_svc && from_idle;
    assign tgt_ch   = after_svc ? resume_ch  : adv_ch;
    assign tgt_end  = after_svc ? resume_end : adv_end;

    always_comb begin
        state_d      = state;
        sel_d        = sel_q;
        done_d       = 1'b0;
        scan_ch_d    = scan_ch;
        resume_ch_d  = resume_ch;
        resume_end_d = resume_end;
        mode_d       = mode_q;
        from_idle_d  = from_idle;
        after_svc_d  = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state_d     = SERVICE;
                        sel_d       = bus.req_ch;
                        from_idle_d = 1'b1;
                    end else if (bus.start && start_ok) begin
                        state_d   = ACTIVE;
                        scan_ch_d = first_ch;
                        mode_d    = bus.mode;
                    end
                end
                ACTIVE: begin
                    if (cnt_zero) state_d = BLANK;
                end
                SERVICE: begin
                    if (cnt_zero) begin
                        state_d     = BLANK;
                        after_svc_d = 1'b1;
                    end
                end
                BLANK: begin
                    if (accept) begin
                        state_d     = SERVICE;
                        sel_d       = bus.req_ch;
                        from_idle_d = tgt_idle;
                        if (!tgt_idle) begin
                            resume_ch_d  = tgt_ch;
                            resume_end_d = tgt_end;
                        end
                    end else if (tgt_idle) begin
                        state_d = IDLE;
                    end else if (tgt_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ACTIVE;
                        scan_ch_d = tgt_ch;
                        mode_d    = bus.mode;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d == ACTIVE) sel_d = scan_ch_d;
        strobe_d = (state_d == ACTIVE) || (state_d == SERVICE);
        busy_d   = (state_d != IDLE);
    end

    assign cnt_load = strobe_d && (state_d != state);
    assign cnt_dec  = ((state == ACTIVE) || (state == SERVICE)) && !cnt_zero;

    dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (bus.dwell),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sel_q      <= '0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            scan_ch    <= '0;
            resume_ch  <= '0;
            resume_end <= 1'b0;
            mode_q     <= 1'b0;
            from_idle  <= 1'b0;
            after_svc  <= 1'b0;
        end else begin
            state      <= state_d;
            sel_q      <= sel_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            scan_ch    <= scan_ch_d;
            resume_ch  <= resume_ch_d;
            resume_end <= resume_end_d;
            mode_q     <= mode_d;
            from_idle  <= from_idle_d;
            after_svc  <= after_svc_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.sel       = sel_q;
    assign bus.strobe    = strobe_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_channel_scan_sequencer.sv
// Scoreboard bench for channel_scan_sequencer: per-cycle expected sel/strobe/busy/done traces.
module tb_channel_scan_sequencer;
    import scan_seq_pkg::*;

    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             strobe;
        logic             busy;
        logic             done;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
`ifdef SEQ_CH_MASK_EN
    logic [N_CH-1:0] ch_en;
`endif
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    channel_scan_sequencer_if #(.DWELL_W(16)) bus ();

    channel_scan_sequencer #(.DWELL_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
`ifdef SEQ_CH_MASK_EN
        .ch_en (ch_en),
`endif
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input int ch, input logic s, input logic b, input logic d);
        obs_t o;
        o.sel    = SEL_W'(ch);
        o.strobe = s;
        o.busy   = b;
        o.done   = d;
        return o;
    endfunction

    function automatic obs_t observed();
        obs_t o;
        o.sel    = bus.sel;
        o.strobe = bus.strobe;
        o.busy   = bus.busy;
        o.done   = bus.done;
        return o;
    endfunction

    // One scanned channel: dwell+1 strobe-high cycles then one blank cycle.
    task automatic push_ch(input int ch, input int dw);
        for (int k = 0; k <= dw; k++) exp_q.push_back(mk(ch, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(ch, 1'b0, 1'b1, 1'b0));
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.mode      = 1'b0;
        bus.dwell     = '0;
        bus.req_valid = 1'b0;
        bus.req_ch    = '0;
    endtask

    task automatic test_reset();
        obs_t got;
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        got = observed();
        checks++;
        if (got !== mk(0, 1'b0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL reset outputs: got %h expected %h", got, mk(0, 1'b0, 1'b0, 1'b0));
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset req_ready: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_single_sweep();
        obs_t e, got;
        int   n = 0;
        bus.mode  = 1'b1;
        bus.dwell = 16'd0;
        for (int ch = 0; ch < N_CH; ch++) push_ch(ch, 0);
        exp_q.push_back(mk(LAST_CH, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(LAST_CH, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            bus.start = (n == 0);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL single_sweep cyc %0d: got sel=%0d strobe=%b busy=%b done=%b expected sel=%0d strobe=%b busy=%b done=%b",
                         n, got.sel, got.strobe, got.busy, got.done, e.sel, e.strobe, e.busy, e.done);
            end
            n++;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_continuous();
        obs_t e, got;
        int   n = 0;
        int   total;
        bus.mode  = 1'b0;
        bus.dwell = 16'd3;
        for (int ch = 0; ch < N_CH; ch++) push_ch(ch, 3);
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(0, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        total = exp_q.size();
        while (exp_q.size() > 0) begin
            bus.start = (n == 0);
            bus.stop  = (n == total - 1);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL continuous cyc %0d: got sel=%0d strobe=%b busy=%b done=%b expected sel=%0d strobe=%b busy=%b done=%b",
                         n, got.sel, got.strobe, got.busy, got.done, e.sel, e.strobe, e.busy, e.done);
            end
            n++;
        end
        idle_inputs();
    endtask

    task automatic test_request_mid_sweep();
        obs_t e, got;
        int   n = 0;
        bus.mode   = 1'b1;
        bus.dwell  = 16'd3;
        bus.req_ch = 4'd11;
        for (int ch = 0; ch <= 4; ch++) push_ch(ch, 3);
        push_ch(11, 3);
        for (int ch = 5; ch < N_CH; ch++) push_ch(ch, 3);
        exp_q.push_back(mk(LAST_CH, 1'b0, 1'b0, 1'b1));
        while (exp_q.size() > 0) begin
            bus.start     = (n == 0);
            bus.req_valid = (n >= 21) && (n <= 25);
            if (bus.req_valid) begin
                checks++;
                if (bus.req_ready !== (n == 25)) begin
                    errors++;
                    $display("FAIL request req_ready cyc %0d: got %b expected %b", n, bus.req_ready, (n == 25));
                end
            end
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL request cyc %0d: got sel=%0d strobe=%b busy=%b done=%b expected sel=%0d strobe=%b busy=%b done=%b",
                         n, got.sel, got.strobe, got.busy, got.done, e.sel, e.strobe, e.busy, e.done);
            end
            n++;
        end
        idle_inputs();
    endtask

    task automatic test_stop_priority();
        obs_t e, got;
        int   n = 0;
        bus.mode  = 1'b0;
        bus.dwell = 16'd2;
        push_ch(0, 2);
        push_ch(1, 2);
        exp_q.push_back(mk(2, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(2, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(2, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            bus.start     = (n == 0) || (n == 9);
            bus.stop      = (n == 9);
            bus.req_valid = (n == 9);
            bus.req_ch    = 4'd7;
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL stop cyc %0d: got sel=%0d strobe=%b busy=%b done=%b expected sel=%0d strobe=%b busy=%b done=%b",
                         n, got.sel, got.strobe, got.busy, got.done, e.sel, e.strobe, e.busy, e.done);
            end
            n++;
        end
        idle_inputs();
    endtask

    task automatic test_idle_request();
        obs_t e, got;
        int   n = 0;
        bus.mode   = 1'b1;
        bus.dwell  = 16'd1;
        bus.req_ch = 4'd6;
        push_ch(6, 1);
        exp_q.push_back(mk(6, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(6, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            bus.start     = (n == 0);
            bus.req_valid = (n == 0);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL idle_request cyc %0d: got sel=%0d strobe=%b busy=%b done=%b expected sel=%0d strobe=%b busy=%b done=%b",
                         n, got.sel, got.strobe, got.busy, got.done, e.sel, e.strobe, e.busy, e.done);
            end
            n++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_service();
        obs_t e, got;
        int   n = 0;
        bus.dwell  = 16'd5;
        bus.req_ch = 4'd9;
        exp_q.push_back(mk(9, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(9, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            bus.req_valid = (n == 0);
            rst           = (n == 2);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_service cyc %0d: got sel=%0d strobe=%b busy=%b done=%b expected sel=%0d strobe=%b busy=%b done=%b",
                         n, got.sel, got.strobe, got.busy, got.done, e.sel, e.strobe, e.busy, e.done);
            end
            if (n == 2) begin
                checks++;
                if (bus.req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_mid_service req_ready: got %b expected 1", bus.req_ready);
                end
            end
            n++;
        end
        rst = 1'b0;
        idle_inputs();
    endtask

`ifdef SEQ_CH_MASK_EN
    task automatic test_mask();
        obs_t e, got;
        int   n = 0;
        bus.mode  = 1'b1;
        bus.dwell = 16'd1;
        ch_en     = 16'h8021;
        push_ch(0, 1);
        push_ch(5, 1);
        push_ch(15, 1);
        exp_q.push_back(mk(15, 1'b0, 1'b0, 1'b1));
        exp_q.push_back(mk(15, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(15, 1'b0, 1'b0, 1'b0));
        while (exp_q.size() > 0) begin
            bus.start = (n == 0) || (n >= 10);
            if (n >= 10) ch_en = '0;
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            got = observed();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mask cyc %0d: got sel=%0d strobe=%b busy=%b done=%b expected sel=%0d strobe=%b busy=%b done=%b",
                         n, got.sel, got.strobe, got.busy, got.done, e.sel, e.strobe, e.busy, e.done);
            end
            n++;
        end
        ch_en = '1;
        idle_inputs();
    endtask
`endif

    initial begin
        rst = 1'b1;
`ifdef SEQ_CH_MASK_EN
        ch_en = '1;
`endif
        idle_inputs();
        test_reset();
        test_single_sweep();
        test_continuous();
        test_request_mid_sweep();
        test_stop_priority();
        test_idle_request();
        test_reset_mid_service();
`ifdef SEQ_CH_MASK_EN
        test_mask();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_scan_sequencer.md
# channel_scan_sequencer

Sequencer that produces the 4-bit channel select and the one-bit strobe feeding the 1-to-16 demultiplexer stage. It sweeps the 16 channels in order with a programmable dwell time and a one-cycle blanking gap between channels. It also accepts out-of-order single-channel requests through a valid/ready handshake. It sits directly upstream of the demux: `sel` drives the demux select and `strobe` drives its data input.

## Interface
- `DWELL_W`, default 16: width of the dwell-time input and internal dwell counter.
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin a sweep (level sampled each cycle).
- `stop`, input, 1: abort all activity.
- `mode`, input, 1: 0 = continuous sweep, 1 = single sweep.
- `dwell`, input, `DWELL_W`: strobe-high length minus one, in cycles.
- `req_valid`, input, 1: single-channel request pending.
- `req_ch`, input, 4: requested channel.
- `req_ready`, output, 1: request can be accepted this cycle.
- `sel`, output, 4: channel select to the demux.
- `strobe`, output, 1: data bit to the demux.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `done`, output, 1: one-cycle pulse at the end of a single sweep.
- `ch_en`, input, 16: per-channel enable. Present only with `SEQ_CH_MASK_EN`.

## Operation
- FSM states: IDLE, ACTIVE, BLANK, SERVICE.
- **IDLE:**
  - `strobe`=0 and `sel` holds its last value.
  - `start` moves to ACTIVE on channel 0, or on the first enabled channel under the mask.
  - An accepted request moves to SERVICE.
  - Request has priority over `start` in the same cycle.
- **ACTIVE:**
  - `sel` = current scan channel and `strobe`=1.
  - The dwell counter loads `dwell` on entry and counts down.
  - When the count reaches 0, go to BLANK. Strobe-high time is `dwell`+1 cycles, so `dwell`=0 gives 1 cycle.
- **BLANK (one cycle):**
  - `strobe`=0 and `sel` holds.
  - If a request is accepted, go to SERVICE, with the resume channel set to the next scan channel.
  - Otherwise, advance to the next scan channel and go to ACTIVE.
- **Channel wrap after 15:**
  - `mode`=0: wrap to 0 and keep scanning.
  - `mode`=1: go to IDLE and pulse `done`.
- **SERVICE:**
  - `sel`=`req_ch` (latched at the handshake) and `strobe`=1 for `dwell`+1 cycles, then BLANK.
  - If it was entered from IDLE, BLANK returns to IDLE; no `done` pulse.
  - If it was entered from a sweep, the sweep resumes at the saved channel.
- **Handshake:**
  - `req_ready`=1 only in IDLE and BLANK.
  - A transfer occurs when `req_valid`&&`req_ready`.
  - `req_ch` is captured in the same cycle.
- **`stop`:**
  - Goes to IDLE on the next edge from any state, with `strobe`=0.
  - Any in-progress request or sweep is discarded.
  - No `done` pulse.
  - `stop` beats `start` and `req_valid` in the same cycle.
- `start` while busy is ignored.
- `dwell` and `mode` are sampled on entry to ACTIVE/SERVICE; later changes affect only the next channel.
- **Reset:**
  - State=IDLE.
  - `sel`=0, `strobe`=0, `busy`=0, `done`=0.
  - `req_ready`=1 in the first cycle after reset.
  - Resume channel = 0.
  - Reset mid-sweep behaves identically.

## Timing
- All outputs are registered except `req_ready`, which is decoded combinationally from the state.
- `start` at edge t gives `sel`=0 and `strobe`=1 from t+1.
- Per-channel period is `dwell`+2 cycles. A full single sweep is 16·(`dwell`+2) cycles.
- `done` is high in the cycle after the last BLANK, coincident with `busy`=0.
- Request accepted at edge t gives `strobe`=1 with `sel`=`req_ch` from t+1.

## Configuration
- Macro: `SEQ_CH_MASK_EN`.
- **Defined:**
  - Adds the `ch_en` port.
  - Disabled channels are skipped with zero cycles spent: a combinational next-enabled search runs at start and at each BLANK.
  - Wrap or end-of-sweep is detected when no enabled channel remains above the current one.
  - `start` with `ch_en`=0 is ignored.
  - If the mask becomes 0 mid-sweep, go to IDLE at the next BLANK and pulse `done`.
  - Requests ignore the mask.
- **Undefined:** no port; all 16 channels are scanned.

## Structure
- **Package `scan_seq_pkg`:**
  - State enum `scan_state_t`.
  - `N_CH`=16.
  - `SEL_W`=4.
  - `LAST_CH`=15.
- **Sub-module `dwell_counter`:**
  - Ports: load, load value, decrement enable, zero flag.
  - Parameterised by `DWELL_W`.
  - Instantiated once and shared by ACTIVE and SERVICE.

## Test plan
- Reset, then `start` with `mode`=1 and `dwell`=0 -> `sel` steps 0..15, `strobe` pattern 1,0 per channel, `done` pulse at cycle 32 after start, `busy` low afterwards.
- `mode`=0, `dwell`=3 -> period 5 cycles; after channel 15 BLANK, `sel`=0 with `strobe`=1 again; `done` never pulses.
- During the sweep on channel 4, hold `req_valid` with `req_ch`=11 -> accepted in channel 4's BLANK; `sel`=11 with `strobe` high for 4 cycles, then BLANK, then `sel`=5.
- `stop` asserted mid-ACTIVE together with `start` and `req_valid` -> IDLE next cycle, `strobe`=0, no `done`, no request accepted.
- Assert `rst` mid-SERVICE -> next cycle `sel`=0, `strobe`=0, `busy`=0, `req_ready`=1.
- With `SEQ_CH_MASK_EN`, `ch_en`=16'h8021, `mode`=1, `dwell`=1 -> channels 0, 5, 15 only, `done` at 9 cycles after start; `ch_en`=0 with `start` -> stays IDLE.
